// File: rtl/ram_phase_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ram_phase_arbiter_pkg                                         |
// | Purpose  : Shared types and defaults for the image-RAM phase arbiter.    |
// |            The base addresses here must match the processor program      |
// |            image, which reads its input at LOAD_BASE and leaves its      |
// |            result at OUT_BASE.                                           |
// | Ports    : none (package)                                                |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package ram_phase_arbiter_pkg;

   localparam int unsigned c_ADDR_W      = 16;
   localparam int unsigned c_DATA_W      = 16;
   localparam logic [15:0] c_LOAD_BASE   = 16'h0000;
   localparam logic [15:0] c_OUT_BASE    = 16'h1000;

   // Job phases; the RAM owner is a pure function of the phase.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_RUN    = 3'd2,
      ST_UNLOAD = 3'd3,
      ST_DONE   = 3'd4
   } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/ram_phase_arbiter_ram_port_mux.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ram_phase_arbiter_ram_port_mux  (ram_port_mux sub-block)      |
// | Purpose  : Combinational RAM-port select. In RUN the processor drives    |
// |            the RAM and sees its read data; in every other phase the      |
// |            host-side request from the arbiter drives the RAM and the     |
// |            processor read data is forced to zero.                        |
// | Ports    : state            current job phase                            |
// |            host_*           arbiter-side RAM request                     |
// |            proc_*           processor RAM request / read data            |
// |            ram_*            physical RAM port                            |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module ram_phase_arbiter_ram_port_mux
   import ram_phase_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W = c_ADDR_W,
   parameter int unsigned DATA_W = c_DATA_W
) (
   input  arb_state_e        state,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_wdata,
   input  logic              host_we,
   input  logic              host_en,
   input  logic [ADDR_W-1:0] proc_addr,
   input  logic [DATA_W-1:0] proc_wdata,
   input  logic              proc_mwrite,
   input  logic              proc_ram_en,
   output logic [DATA_W-1:0] proc_rdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic              ram_we,
   output logic              ram_en,
   input  logic [DATA_W-1:0] ram_rdata
);

   logic w_proc_owns;
   assign w_proc_owns = (state == ST_RUN);

   always_comb begin
      ram_addr   = host_addr;
      ram_wdata  = host_wdata;
      ram_we     = host_we;
      ram_en     = host_en;
      proc_rdata = '0;
      if (w_proc_owns) begin
         ram_addr   = proc_addr;
         ram_wdata  = proc_wdata;
         ram_we     = proc_mwrite;
         ram_en     = proc_ram_en;
         proc_rdata = ram_rdata;
      end
   end

endmodule
`default_nettype wire

// File: rtl/ram_phase_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ram_phase_arbiter                                             |
// | Purpose  : Sequences one image job through the shared data RAM:          |
// |            LOAD (host writes input) -> RUN (processor owns RAM until     |
// |            end-of-process) -> UNLOAD (result streamed to host) -> DONE.  |
// | Ports    : clk, rst_n        clock, synchronous active-low reset         |
// |            start             job start pulse (honoured in IDLE/DONE)     |
// |            host_wr_*         host input stream (valid/ready)             |
// |            host_rd_*         result stream to host (valid/ready)         |
// |            busy/done/err     job status                                  |
// |            proc_*            processor reset, RAM request, read data     |
// |            ram_*             physical RAM port (1-cycle read latency)    |
// | Config   : `define RAM_ARB_WATCHDOG_EN adds a RUN-phase cycle limit      |
// |            (TIMEOUT_CYCLES) that aborts to DONE with err=1.              |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module ram_phase_arbiter
   import ram_phase_arbiter_pkg::*;
#(
   parameter int unsigned       ADDR_W         = c_ADDR_W,
   parameter int unsigned       DATA_W         = c_DATA_W,
   parameter logic [ADDR_W-1:0] LOAD_BASE      = ADDR_W'(c_LOAD_BASE),
   parameter int unsigned       LOAD_WORDS     = 4096,
   parameter logic [ADDR_W-1:0] OUT_BASE       = ADDR_W'(c_OUT_BASE),
   parameter int unsigned       OUT_WORDS      = 4096,
   parameter int unsigned       TIMEOUT_CYCLES = 1000000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              host_wr_valid,
   output logic              host_wr_ready,
   input  logic [DATA_W-1:0] host_wr_data,
   output logic              host_rd_valid,
   input  logic              host_rd_ready,
   output logic [DATA_W-1:0] host_rd_data,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              proc_rst_n,
   input  logic [ADDR_W-1:0] proc_addr,
   input  logic [DATA_W-1:0] proc_wdata,
   output logic [DATA_W-1:0] proc_rdata,
   input  logic              proc_mwrite,
   input  logic              proc_ram_en,
   input  logic              proc_eop,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              ram_we,
   output logic              ram_en
);

   // Counters carry one extra bit so a full 2^ADDR_W word count is representable.
   localparam int unsigned        c_CNT_W     = ADDR_W + 1;
   localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
   localparam logic [c_CNT_W-1:0] c_LOAD_LAST = c_CNT_W'(LOAD_WORDS - 1);
   localparam logic [c_CNT_W-1:0] c_OUT_LAST  = c_CNT_W'(OUT_WORDS - 1);
   localparam logic [c_CNT_W-1:0] c_OUT_CNT   = c_CNT_W'(OUT_WORDS);

   arb_state_e          state_q, state_d;
   logic [c_CNT_W-1:0]  cnt_q, cnt_d;          // LOAD writes / UNLOAD reads issued
   logic [c_CNT_W-1:0]  acc_q, acc_d;          // UNLOAD words accepted by host
   logic                inflight_q, inflight_d;
   logic                rd_valid_q, rd_valid_d;
   logic [DATA_W-1:0]   rd_data_q, rd_data_d;
   logic                run_first_q, run_first_d;

   logic                w_rd_fire;
   logic                w_rd_issue;
   logic                w_timeout;
   logic                w_wd_trip;
   logic                w_job_start;
   logic [ADDR_W-1:0]   w_host_addr;
   logic [DATA_W-1:0]   w_host_wdata;
   logic                w_host_we;
   logic                w_host_en;

   assign w_rd_fire = rd_valid_q && host_rd_ready;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      acc_d        = acc_q;
      inflight_d   = 1'b0;
      rd_valid_d   = rd_valid_q;
      rd_data_d    = rd_data_q;
      run_first_d  = 1'b0;
      w_rd_issue   = 1'b0;
      w_wd_trip    = 1'b0;
      w_job_start  = 1'b0;
      w_host_addr  = '0;
      w_host_wdata = '0;
      w_host_we    = 1'b0;
      w_host_en    = 1'b0;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d     = ST_LOAD;
               cnt_d       = '0;
               acc_d       = '0;
               w_job_start = 1'b1;
            end
         end
         ST_LOAD: begin
            // Ready is constant in LOAD, so valid alone is an accept.
            if (host_wr_valid) begin
               w_host_en    = 1'b1;
               w_host_we    = 1'b1;
               w_host_addr  = LOAD_BASE + cnt_q[ADDR_W-1:0];
               w_host_wdata = host_wr_data;
               cnt_d        = cnt_q + c_CNT_ONE;
               if (cnt_q == c_LOAD_LAST) begin
                  state_d     = ST_RUN;
                  run_first_d = 1'b1;
               end
            end
         end
         ST_RUN: begin
            // The first RUN cycle ignores eop: the core may still show a
            // stale flag while coming out of reset.
            if (!run_first_q && proc_eop) begin
               state_d = ST_UNLOAD;
               cnt_d   = '0;
               acc_d   = '0;
            end else if (w_timeout) begin
               state_d   = ST_DONE;
               w_wd_trip = 1'b1;
            end
         end
         ST_UNLOAD: begin
            // Only issue when the captured word will have somewhere to land.
            w_rd_issue = !inflight_q && (!rd_valid_q || w_rd_fire) && (cnt_q != c_OUT_CNT);
            if (w_rd_issue) begin
               w_host_en   = 1'b1;
               w_host_addr = OUT_BASE + cnt_q[ADDR_W-1:0];
               cnt_d       = cnt_q + c_CNT_ONE;
               inflight_d  = 1'b1;
            end
            if (inflight_q) begin
               rd_valid_d = 1'b1;
               rd_data_d  = ram_rdata;
            end else if (w_rd_fire) begin
               rd_valid_d = 1'b0;
            end
            if (w_rd_fire) begin
               acc_d = acc_q + c_CNT_ONE;
               if (acc_q == c_OUT_LAST) begin
                  state_d = ST_DONE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         acc_q       <= '0;
         inflight_q  <= 1'b0;
         rd_valid_q  <= 1'b0;
         rd_data_q   <= '0;
         run_first_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         inflight_q  <= inflight_d;
         rd_valid_q  <= rd_valid_d;
         rd_data_q   <= rd_data_d;
         run_first_q <= run_first_d;
      end
   end

`ifdef RAM_ARB_WATCHDOG_EN
   localparam logic [31:0] c_WD_LAST = 32'(TIMEOUT_CYCLES - 1);

   logic [31:0] wd_cnt_q, wd_cnt_d;
   logic        err_q, err_d;

   // Held at zero outside RUN, so it restarts on every RUN entry.
   assign w_timeout = (state_q == ST_RUN) && (wd_cnt_q == c_WD_LAST);

   always_comb begin
      wd_cnt_d = (state_q == ST_RUN) ? wd_cnt_q + 32'd1 : '0;
      err_d    = err_q;
      if (w_job_start) begin
         err_d = 1'b0;
      end else if (w_wd_trip) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wd_cnt_q <= '0;
         err_q    <= 1'b0;
      end else begin
         wd_cnt_q <= wd_cnt_d;
         err_q    <= err_d;
      end
   end

   assign err = err_q;
`else
   logic unused_wd;
   assign w_timeout = 1'b0;
   assign err       = 1'b0;
   assign unused_wd = ^{w_wd_trip, w_job_start, TIMEOUT_CYCLES[0]};
`endif

   assign busy          = (state_q == ST_LOAD) || (state_q == ST_RUN) || (state_q == ST_UNLOAD);
   assign done          = (state_q == ST_DONE);
   assign host_wr_ready = (state_q == ST_LOAD);
   assign proc_rst_n    = (state_q == ST_RUN);
   assign host_rd_valid = rd_valid_q;
   assign host_rd_data  = rd_data_q;

   ram_phase_arbiter_ram_port_mux #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_ram_port_mux (
      .state       (state_q),
      .host_addr   (w_host_addr),
      .host_wdata  (w_host_wdata),
      .host_we     (w_host_we),
      .host_en     (w_host_en),
      .proc_addr   (proc_addr),
      .proc_wdata  (proc_wdata),
      .proc_mwrite (proc_mwrite),
      .proc_ram_en (proc_ram_en),
      .proc_rdata  (proc_rdata),
      .ram_addr    (ram_addr),
      .ram_wdata   (ram_wdata),
      .ram_we      (ram_we),
      .ram_en      (ram_en),
      .ram_rdata   (ram_rdata)
   );

endmodule
`default_nettype wire

// File: tb/tb_ram_phase_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_ram_phase_arbiter                                          |
// | Purpose  : Directed + randomized self-checking bench for                 |
// |            ram_phase_arbiter with a 4-word LOAD/UNLOAD job, a RAM model  |
// |            and an image reference array.                                 |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_ram_phase_arbiter;

   localparam int unsigned NW = 4;
   localparam logic [15:0] LB = 16'h0000;
   localparam logic [15:0] OB = 16'h1000;
   localparam int unsigned TO = 50;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        host_wr_valid = 1'b0;
   logic        host_wr_ready;
   logic [15:0] host_wr_data = '0;
   logic        host_rd_valid;
   logic        host_rd_ready = 1'b0;
   logic [15:0] host_rd_data;
   logic        busy, done, err, proc_rst_n;
   logic [15:0] proc_addr = '0;
   logic [15:0] proc_wdata = '0;
   logic [15:0] proc_rdata;
   logic        proc_mwrite = 1'b0;
   logic        proc_ram_en = 1'b0;
   logic        proc_eop = 1'b0;
   logic [15:0] ram_addr, ram_wdata;
   logic [15:0] ram_rdata = '0;
   logic        ram_we, ram_en;

   logic [15:0] mem     [0:65535];   // physical RAM contents
   logic [15:0] ref_mem [0:65535];   // what the image should hold

   int n_cmp = 0;
   int n_bad = 0;

   ram_phase_arbiter #(
      .ADDR_W(16), .DATA_W(16), .LOAD_BASE(LB), .LOAD_WORDS(NW),
      .OUT_BASE(OB), .OUT_WORDS(NW), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .host_wr_valid(host_wr_valid), .host_wr_ready(host_wr_ready), .host_wr_data(host_wr_data),
      .host_rd_valid(host_rd_valid), .host_rd_ready(host_rd_ready), .host_rd_data(host_rd_data),
      .busy(busy), .done(done), .err(err), .proc_rst_n(proc_rst_n),
      .proc_addr(proc_addr), .proc_wdata(proc_wdata), .proc_rdata(proc_rdata),
      .proc_mwrite(proc_mwrite), .proc_ram_en(proc_ram_en), .proc_eop(proc_eop),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
      .ram_we(ram_we), .ram_en(ram_en)
   );

   always #5 clk = ~clk;

   // Synchronous RAM, read data valid one cycle after the address.
   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_we) mem[ram_addr] <= ram_wdata;
         else        ram_rdata     <= mem[ram_addr];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_vals(input string pfx);
      chk({pfx, "_busy"}, busy, 0);
      chk({pfx, "_done"}, done, 0);
      chk({pfx, "_err"}, err, 0);
      chk({pfx, "_wr_ready"}, host_wr_ready, 0);
      chk({pfx, "_rd_valid"}, host_rd_valid, 0);
      chk({pfx, "_ram_we"}, ram_we, 0);
      chk({pfx, "_ram_en"}, ram_en, 0);
      chk({pfx, "_proc_rst_n"}, proc_rst_n, 0);
      chk({pfx, "_ram_addr"}, ram_addr, 0);
      chk({pfx, "_ram_wdata"}, ram_wdata, 0);
      chk({pfx, "_rd_data"}, host_rd_data, 0);
      chk({pfx, "_proc_rdata"}, proc_rdata, 0);
   endtask

   // Hold reset n cycles with processor strobes active; they must not reach the RAM.
   task automatic reset_seq(input int n, input logic st);
      @(negedge clk);
      rst_n = 1'b0; start = st; host_wr_valid = 1'b0; host_rd_ready = 1'b0; proc_eop = 1'b0;
      proc_ram_en = 1'b1; proc_mwrite = 1'b1; proc_addr = 16'hF0F0; proc_wdata = 16'h0BAD;
      repeat (n) @(negedge clk);
      rst_n = 1'b1; start = 1'b0;
      #2;
      chk_reset_vals("rst");
      @(negedge clk);
      #2;
      chk("idle_busy", busy, 0);
      chk("idle_ram_en", ram_en, 0);
      chk("idle_proc_rst_n", proc_rst_n, 0);
      proc_ram_en = 1'b0; proc_mwrite = 1'b0;
   endtask

   task automatic start_job();
      @(negedge clk);
      start = 1'b1;
      #2;
      chk("start_busy_pre", busy, 0);
   endtask

   task automatic load_job(input logic [15:0] w [NW], input bit rnd);
      int k = 0;
      int budget = 0;
      while (k < NW && budget < 64) begin
         @(negedge clk);
         start         = rnd && ($urandom_range(0, 3) == 0);
         host_wr_valid = rnd ? ($urandom_range(0, 2) != 0) : (budget % 2 == 0);
         host_wr_data  = host_wr_valid ? w[k] : 16'hDEAD;
         #2;
         chk("load_wr_ready", host_wr_ready, 1);
         chk("load_busy", busy, 1);
         chk("load_done", done, 0);
         if (host_wr_valid) begin
            chk("load_ram_en", ram_en, 1);
            chk("load_ram_we", ram_we, 1);
            chk("load_ram_addr", ram_addr, LB + 16'(k));
            chk("load_ram_wdata", ram_wdata, w[k]);
            ref_mem[LB + 16'(k)] = w[k];
            k++;
         end else begin
            chk("load_gap_ram_en", ram_en, 0);
         end
         budget++;
      end
      if (k < NW) chk("load_budget", k, NW);
   endtask

   task automatic run_job(input logic [15:0] ow [NW], input bit abort);
      // First RUN cycle: stale eop and a host write attempt must both be ignored.
      @(negedge clk);
      start = 1'b0; host_wr_valid = 1'b1; host_wr_data = 16'hBEEF; proc_eop = 1'b1;
      proc_ram_en = 1'b1; proc_mwrite = 1'b1; proc_addr = OB; proc_wdata = 16'h5555;
      #2;
      chk("run1_proc_rst_n", proc_rst_n, 1);
      chk("run1_wr_ready", host_wr_ready, 0);
      chk("run1_ram_we", ram_we, 1);
      chk("run1_ram_en", ram_en, 1);
      chk("run1_ram_addr", ram_addr, OB);
      chk("run1_ram_wdata", ram_wdata, 16'h5555);
      ref_mem[OB] = 16'h5555;
      @(negedge clk);
      host_wr_valid = 1'b0; proc_eop = 1'b0; proc_mwrite = 1'b0; proc_addr = LB;
      #2;
      chk("run2_eop_ignored", proc_rst_n, 1);
      chk("run2_ram_we", ram_we, 0);
      chk("run2_ram_addr", ram_addr, LB);
      if (abort) begin
         reset_seq(1, 1'b0);
         return;
      end
      for (int i = 0; i < NW; i++) begin
         @(negedge clk);
         proc_mwrite = 1'b1; proc_addr = OB + 16'(i); proc_wdata = ow[i];
         #2;
         if (i == 0) chk("run_proc_rdata", proc_rdata, ref_mem[LB]);
         chk("run_wr_addr", ram_addr, OB + 16'(i));
         chk("run_wr_data", ram_wdata, ow[i]);
         chk("run_wr_we", ram_we, 1);
         ref_mem[OB + 16'(i)] = ow[i];
      end
      @(negedge clk);
      proc_ram_en = 1'b0; proc_mwrite = 1'b0; proc_eop = 1'b1;
      #2;
      chk("eop_cycle_proc_rst_n", proc_rst_n, 1);
      chk("eop_cycle_ram_en", ram_en, 0);
   endtask

   task automatic unload_job(input bit pat);
      int k = 0;
      int issued = 0;
      int budget = 0;
      bit rdy;
      logic prev_stall = 1'b0;
      logic [15:0] prev_data = '0;
      while (k < NW && budget < 100) begin
         @(negedge clk);
         proc_eop = 1'b0;
         rdy = pat ? ((budget % 4 == 0) || (budget % 4 == 3)) : ($urandom_range(0, 1) == 1);
         host_rd_ready = rdy;
         start = ($urandom_range(0, 3) == 0);
         #2;
         chk("unl_proc_rst_n", proc_rst_n, 0);
         chk("unl_proc_rdata", proc_rdata, 0);
         chk("unl_ram_we", ram_we, 0);
         chk("unl_busy", busy, 1);
         if (ram_en) begin
            chk("unl_overread", issued < NW, 1);
            chk("unl_rd_addr", ram_addr, OB + 16'(issued));
            issued++;
         end
         if (prev_stall) begin
            chk("unl_hold_valid", host_rd_valid, 1);
            chk("unl_hold_data", host_rd_data, prev_data);
         end
         if (host_rd_valid) begin
            chk("unl_data", host_rd_data, ref_mem[OB + 16'(k)]);
            if (rdy) k++;
         end
         prev_stall = host_rd_valid && !rdy;
         prev_data  = host_rd_data;
         budget++;
      end
      if (k < NW) chk("unl_budget", k, NW);
      @(negedge clk);
      start = 1'b0; host_rd_ready = 1'b0;
      #2;
      chk("fin_done", done, 1);
      chk("fin_busy", busy, 0);
      chk("fin_rd_valid", host_rd_valid, 0);
      chk("fin_ram_en", ram_en, 0);
      chk("fin_issued", issued, NW);
   endtask

   initial begin
      logic [15:0] w [NW];
      logic [15:0] ow [NW];
      int run_cyc;
      int guard;

      // Reset with start held high: must stay IDLE with reset outputs.
      reset_seq(3, 1'b1);

      // Job 1: directed words, fixed ready pattern 1,0,0,1.
      w  = '{16'h00A1, 16'h00A2, 16'h00A3, 16'h00A4};
      ow = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
      start_job();
      load_job(w, 1'b0);
      run_job(ow, 1'b0);
      unload_job(1'b1);

      // Job 2: restarted from DONE, aborted by reset mid-RUN.
      for (int i = 0; i < NW; i++) w[i] = 16'($urandom);
      start_job();
      load_job(w, 1'b1);
      run_job(ow, 1'b1);

      // Job 3: full random job after the abort.
      for (int i = 0; i < NW; i++) begin
         w[i]  = 16'($urandom);
         ow[i] = 16'($urandom);
      end
      start_job();
      load_job(w, 1'b1);
      run_job(ow, 1'b0);
      unload_job(1'b0);

      // Job 4: processor never signals end-of-process.
      for (int i = 0; i < NW; i++) w[i] = 16'($urandom);
      start_job();
      load_job(w, 1'b1);
`ifdef RAM_ARB_WATCHDOG_EN
      run_cyc = 0;
      guard   = 0;
      do begin
         @(negedge clk);
         start = 1'b0; host_wr_valid = 1'b0; proc_eop = 1'b0;
         #2;
         if (proc_rst_n) run_cyc++;
         chk("wd_ram_en", ram_en, 0);
         guard++;
      end while (proc_rst_n && guard < 200);
      chk("wd_run_cycles", run_cyc, TO);
      chk("wd_done", done, 1);
      chk("wd_err", err, 1);
      chk("wd_rd_valid", host_rd_valid, 0);
      @(negedge clk);
      start = 1'b1;
      #2;
      chk("wd_err_held", err, 1);
      @(negedge clk);
      start = 1'b0;
      #2;
      chk("wd_err_cleared", err, 0);
      chk("wd_restart_load", host_wr_ready, 1);
`else
      run_cyc = 0;
      guard   = 0;
      repeat (60) begin
         @(negedge clk);
         start = 1'b0; host_wr_valid = 1'b0; proc_eop = 1'b0;
         #2;
         chk("norun_limit_proc_rst_n", proc_rst_n, 1);
         chk("norun_limit_err", err, 0);
         run_cyc++;
      end
      guard = run_cyc;
`endif
      reset_seq(1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: observed no finish, required finish before 500000");
      $fatal(1, "bench time limit expired");
   end

endmodule
`default_nettype wire
